demux_3s_32b_buf: RTL and testbench

- 1-to-8 routing demultiplexer for 32-bit words; the distribution counterpart of the 8-input select-based muxes on the datapath.
- Accepts one word per cycle on a valid/ready input channel, steers it by a 3-bit select to one of 8 output channels, and holds it there.
- Each output has a 1-entry holding register with its own valid/ready handshake.
- Sits between a single producer (bus/writeback source) and up to 8 independent consumers.

---
 rtl/demux_3s_32b_buf.sv | 139 +++++++++++++
 tb/tb_demux_3s_32b_buf.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_3s_32b_buf.sv
// demux_3s_32b_buf: 1-to-8 routing demultiplexer for DW-bit words.
// A single producer hands one word per cycle to this block, which steers it
// by a 3-bit select into one of eight 1-entry holding registers. Each holding
// register presents its word to an independent consumer.
//
// Handshake semantics (all channels): a transfer happens on a rising clk edge
// where valid=1 and ready=1 in the cycle before that edge. A producer holding
// valid=1 with ready=0 must keep its data/select stable. ready never depends
// on the valid of the same channel.
//
// Optional feature macro: DEMUX_BCAST_EN. When it is defined, in_bcast=1
// writes the word into all eight slots at once, provided every slot is free.
// When it is undefined, in_bcast is ignored and no broadcast logic exists.
module demux_3s_32b_buf #(
  parameter int DW   = 32,
  parameter int NOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic [2:0]           in_sel,
  input  logic                 in_bcast,
  output logic [NOUT-1:0]      out_valid,
  input  logic [NOUT-1:0]      out_ready,
  output logic [NOUT*DW-1:0]   out_data,
  output logic [7:0]           drop_cnt
);

  localparam logic [7:0] DROP_MAX = 8'hFF;

  // Per-slot holding state.
  logic [NOUT-1:0] valid_q;
  logic [DW-1:0]   data_q [NOUT];
  logic [7:0]      drop_q;

  // Routing and handshake decode.
  logic [NOUT-1:0] slot_free;
  logic [NOUT-1:0] sel_onehot;
  logic [NOUT-1:0] route_mask;
  logic [NOUT-1:0] load_mask;
  logic            ready_c;
  logic            accept;
  logic            stall;

  // A slot can take a new word when it is empty or being drained this cycle;
  // the drain-and-refill case is what gives 1 word/cycle/slot throughput.
  always_comb begin
    slot_free = ~valid_q | out_ready;
  end

  // One-hot decode of the destination index.
  always_comb begin
    sel_onehot         = '0;
    sel_onehot[in_sel] = 1'b1;
  end

`ifdef DEMUX_BCAST_EN
  // Broadcast needs every slot free at once; otherwise route to in_sel only.
  always_comb begin
    ready_c    = slot_free[in_sel];
    route_mask = sel_onehot;
    if (in_bcast) begin
      ready_c    = &slot_free;
      route_mask = '1;
    end
  end
`else
  // Broadcast is not built: in_bcast is deliberately left unused.
  logic bcast_unused;
  assign bcast_unused = in_bcast;

  // Plain select-based routing.
  always_comb begin
    ready_c    = slot_free[in_sel];
    route_mask = sel_onehot;
  end
`endif

  // Accept / stall qualification and the per-slot load strobes.
  always_comb begin
    accept    = in_valid & ready_c;
    stall     = in_valid & ~ready_c;
    load_mask = accept ? route_mask : '0;
  end

  // Slot occupancy: a load wins over a simultaneous drain, so a drained slot
  // that is refilled on the same edge stays valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < NOUT; k++) begin
        if (load_mask[k]) begin
          valid_q[k] <= 1'b1;
        end else if (out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  // Slot payload: only written on a load; a drain leaves the last word visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NOUT; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NOUT; k++) begin
        if (load_mask[k]) begin
          data_q[k] <= in_data;
        end
      end
    end
  end

  // Saturating count of cycles where the producer offered a word we refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (stall && (drop_q != DROP_MAX)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  // Flatten the slot registers onto the output bus (register-only path).
  always_comb begin
    for (int k = 0; k < NOUT; k++) begin
      out_data[k*DW +: DW] = data_q[k];
    end
  end

  assign in_ready  = ready_c;
  assign out_valid = valid_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux_3s_32b_buf.sv
// tb_demux_3s_32b_buf: table-driven directed bench for demux_3s_32b_buf,
// followed by hand-written multi-cycle sequences (async reset, saturation,
// streaming, broadcast).
module tb_demux_3s_32b_buf;

  localparam int DW   = 32;
  localparam int NOUT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_data;
  logic [2:0]           in_sel;
  logic                 in_bcast;
  logic [NOUT-1:0]      out_valid;
  logic [NOUT-1:0]      out_ready;
  logic [NOUT*DW-1:0]   out_data;
  logic [7:0]           drop_cnt;

  demux_3s_32b_buf #(.DW(DW), .NOUT(NOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_cnt  (drop_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] slot(input int k);
    return out_data[k*DW +: DW];
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic drive(input logic v, input logic [2:0] s, input logic [DW-1:0] d,
                       input logic b, input logic [NOUT-1:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    in_bcast  = b;
    out_ready = r;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    drive(1'b0, 3'd0, '0, 1'b0, '0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            v;
    logic [2:0]      sel;
    logic [DW-1:0]   data;
    logic [NOUT-1:0] rdy;
    logic            exp_rdy;
    logic [NOUT-1:0] exp_valid;
    logic [2:0]      chk_slot;
    logic [DW-1:0]   exp_data;
    logic [7:0]      exp_drop;
  } vec_t;

  vec_t vecs [12];

  initial begin
    //            v    sel   data           rdy    exp_rdy exp_valid slot exp_data       drop
    vecs[0]  = '{1'b1, 3'd3, 32'hDEADBEEF, 8'h00, 1'b1, 8'h08, 3'd3, 32'hDEADBEEF, 8'd0};
    vecs[1]  = '{1'b1, 3'd3, 32'h11111111, 8'h00, 1'b0, 8'h08, 3'd3, 32'hDEADBEEF, 8'd1};
    vecs[2]  = '{1'b1, 3'd3, 32'h11111111, 8'h00, 1'b0, 8'h08, 3'd3, 32'hDEADBEEF, 8'd2};
    vecs[3]  = '{1'b1, 3'd5, 32'h00000001, 8'h08, 1'b1, 8'h20, 3'd5, 32'h00000001, 8'd2};
    vecs[4]  = '{1'b1, 3'd5, 32'h00000002, 8'h20, 1'b1, 8'h20, 3'd5, 32'h00000002, 8'd2};
    vecs[5]  = '{1'b1, 3'd5, 32'h00000003, 8'h20, 1'b1, 8'h20, 3'd5, 32'h00000003, 8'd2};
    vecs[6]  = '{1'b0, 3'd5, 32'h00000000, 8'h20, 1'b1, 8'h00, 3'd5, 32'h00000003, 8'd2};
    vecs[7]  = '{1'b1, 3'd2, 32'hCAFEF00D, 8'h00, 1'b1, 8'h04, 3'd2, 32'hCAFEF00D, 8'd2};
    vecs[8]  = '{1'b1, 3'd6, 32'hA5A5A5A5, 8'h00, 1'b1, 8'h44, 3'd2, 32'hCAFEF00D, 8'd2};
    vecs[9]  = '{1'b0, 3'd6, 32'h00000000, 8'h00, 1'b0, 8'h44, 3'd6, 32'hA5A5A5A5, 8'd2};
    vecs[10] = '{1'b1, 3'd2, 32'h00000077, 8'h04, 1'b1, 8'h44, 3'd2, 32'h00000077, 8'd2};
    vecs[11] = '{1'b1, 3'd7, 32'hFFFFFFFF, 8'h40, 1'b1, 8'h84, 3'd7, 32'hFFFFFFFF, 8'd2};
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'd0, '0, 1'b0, '0);
    @(negedge clk);
    do_reset();

    // Reset state.
    chk("reset_out_valid", DW'(out_valid), '0);
    chk("reset_drop_cnt", DW'(drop_cnt), '0);
    chk("reset_out_data_or", DW'(|out_data), '0);

    // Table-driven section.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].v, vecs[i].sel, vecs[i].data, 1'b0, vecs[i].rdy);
      #1;
      chk($sformatf("vec%0d_in_ready", i), DW'(in_ready), DW'(vecs[i].exp_rdy));
      step();
      chk($sformatf("vec%0d_out_valid", i), DW'(out_valid), DW'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_slot%0d", i, vecs[i].chk_slot), slot(int'(vecs[i].chk_slot)), vecs[i].exp_data);
      chk($sformatf("vec%0d_drop_cnt", i), DW'(drop_cnt), DW'(vecs[i].exp_drop));
    end

    // Streaming through slot 0 with the consumer always ready.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] w;
      w = DW'(32'h100 + i * 32'h11);
      exp_q.push_back(w);
      drive(1'b1, 3'd0, w, 1'b0, 8'h01);
      #1;
      chk($sformatf("stream%0d_in_ready", i), DW'(in_ready), 32'd1);
      step();
      chk($sformatf("stream%0d_valid0", i), DW'(out_valid[0]), 32'd1);
      chk($sformatf("stream%0d_data0", i), slot(0), exp_q.pop_front());
    end

    // Fill all slots, build drop_cnt to 17, then reset mid-cycle.
    do_reset();
    for (int k = 0; k < NOUT; k++) begin
      drive(1'b1, 3'(k), DW'(32'hC0DE0000 + k), 1'b0, '0);
      step();
    end
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 3'd0, 32'h0BAD0BAD, 1'b0, '0);
      step();
    end
    chk("prereset_out_valid", DW'(out_valid), 32'hFF);
    chk("prereset_drop_cnt", DW'(drop_cnt), 32'd17);
    chk("prereset_slot7", slot(7), 32'hC0DE0007);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", DW'(out_valid), '0);
    chk("async_rst_drop_cnt", DW'(drop_cnt), '0);
    chk("async_rst_out_data_or", DW'(|out_data), '0);
    @(negedge clk);
    drive(1'b0, 3'd0, '0, 1'b0, '0);
    rst_n = 1'b1;

    // Saturation of drop_cnt against a stalled slot.
    drive(1'b1, 3'd1, 32'h5A5A0001, 1'b0, '0);
    step();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 3'd1, 32'h5A5A0002, 1'b0, '0);
      step();
      if (i == 9) chk("drop_cnt_10", DW'(drop_cnt), 32'd10);
      if (i == 254) chk("drop_cnt_255", DW'(drop_cnt), 32'd255);
    end
    chk("drop_cnt_sat", DW'(drop_cnt), 32'd255);
    chk("sat_slot1_held", slot(1), 32'h5A5A0001);

    // Broadcast request against one occupied, stalled slot.
    do_reset();
    drive(1'b1, 3'd4, 32'h44444444, 1'b0, '0);
    step();
    drive(1'b1, 3'd2, 32'h12345678, 1'b1, '0);
    #1;
`ifdef DEMUX_BCAST_EN
    chk("bcast_blocked_in_ready", DW'(in_ready), 32'd0);
    step();
    chk("bcast_blocked_valid", DW'(out_valid), 32'h10);
    chk("bcast_blocked_drop", DW'(drop_cnt), 32'd1);
    drive(1'b1, 3'd2, 32'h12345678, 1'b1, 8'h10);
    #1;
    chk("bcast_release_in_ready", DW'(in_ready), 32'd1);
    step();
    chk("bcast_out_valid", DW'(out_valid), 32'hFF);
    for (int k = 0; k < NOUT; k++) begin
      chk($sformatf("bcast_slot%0d", k), slot(k), 32'h12345678);
    end
`else
    chk("nobcast_in_ready", DW'(in_ready), 32'd1);
    step();
    chk("nobcast_out_valid", DW'(out_valid), 32'h14);
    chk("nobcast_slot2", slot(2), 32'h12345678);
    chk("nobcast_slot0", slot(0), 32'h00000000);
    chk("nobcast_slot4", slot(4), 32'h44444444);
    chk("nobcast_drop", DW'(drop_cnt), 32'd0);
`endif

    drive(1'b0, 3'd0, '0, 1'b0, '0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
